// File: rtl/assert_deassert_filter_pkg.sv
// Shared definitions for the assert/deassert input qualifier.
// Holds the default parameter values, the legal synchroniser depth range,
// the per-channel action encoding and the counter-width helper.
package assert_deassert_filter_pkg;

  localparam int DEFAULT_WIDTH           = 4;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int MIN_SYNC_STAGES         = 2;
  localparam int MAX_SYNC_STAGES         = 4;
  localparam int DEFAULT_ASSERT_CYCLES   = 4;
  localparam int DEFAULT_DEASSERT_CYCLES = 8;

  // What a channel does on the next enabled clock edge.
  typedef enum logic [1:0] {
    ACT_CLEAR,
    ACT_COUNT,
    ACT_FLIP
  } chan_act_e;

  // The counter only ever holds values up to thr-1, so clog2 of the larger
  // threshold is enough; a one-bit floor keeps the vector legal when both
  // thresholds are 1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/assert_deassert_filter_channel.sv
// One qualifier channel: synchroniser chain, consecutive-sample counter and
// the registered out / rise / fall flops.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low
//   en     1 = qualify, 0 = hold out and clear the counter
//   in     raw asynchronous input bit
//   out    qualified level
//   rise   one-cycle strobe in the first cycle out reads 1
//   fall   one-cycle strobe in the first cycle out reads 0
module assert_deassert_filter_channel
  import assert_deassert_filter_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int ASSERT_CYCLES   = DEFAULT_ASSERT_CYCLES,
  parameter int DEASSERT_CYCLES = DEFAULT_DEASSERT_CYCLES,
  parameter bit RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(ASSERT_CYCLES, DEASSERT_CYCLES);
  localparam logic [CNT_W-1:0] ASSERT_LAST   = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEASSERT_LAST = CNT_W'(DEASSERT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       thr_last;
  chan_act_e              act;

  // A sample that disagrees with out either extends the run or, when the run
  // reaches the threshold for the current level, flips out. Any agreeing
  // sample (or en low) restarts the run from zero.
  always_comb begin
    s        = sync[SYNC_STAGES-1];
    thr_last = out ? DEASSERT_LAST : ASSERT_LAST;
    act      = ACT_CLEAR;
    if (en && (s != out)) begin
      act = (cnt == thr_last) ? ACT_FLIP : ACT_COUNT;
    end
  end

  // The synchroniser keeps sampling even while en is low so that the first
  // enabled edge already sees a settled value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= {SYNC_STAGES{RESET_VAL}};
      out  <= RESET_VAL;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
      rise <= 1'b0;
      fall <= 1'b0;
      case (act)
        ACT_COUNT: cnt <= cnt + 1'b1;
        ACT_FLIP: begin
          out  <= s;
          cnt  <= '0;
          rise <= s;
          fall <= ~s;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/assert_deassert_filter.sv
// Multi-channel input qualifier. Each bit of in is synchronised and must hold
// a new level for ASSERT_CYCLES (rising) or DEASSERT_CYCLES (falling)
// consecutive synced samples before out follows it.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low
//   en     1 = qualify, 0 = hold out and clear all counters
//   in     [WIDTH] raw asynchronous inputs
//   out    [WIDTH] qualified levels
//   rise   [WIDTH] per-channel one-cycle rising strobes
//   fall   [WIDTH] per-channel one-cycle falling strobes
module assert_deassert_filter
  import assert_deassert_filter_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int ASSERT_CYCLES   = DEFAULT_ASSERT_CYCLES,
  parameter int DEASSERT_CYCLES = DEFAULT_DEASSERT_CYCLES,
  parameter bit RESET_VAL       = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Reject parameter sets the channel logic cannot implement.
  if (WIDTH < 1) begin : g_bad_width
    $error("assert_deassert_filter: WIDTH must be at least 1");
  end
  if ((SYNC_STAGES < MIN_SYNC_STAGES) || (SYNC_STAGES > MAX_SYNC_STAGES)) begin : g_bad_sync
    $error("assert_deassert_filter: SYNC_STAGES must be within 2..4");
  end
  if (ASSERT_CYCLES < 1) begin : g_bad_assert
    $error("assert_deassert_filter: ASSERT_CYCLES must be at least 1");
  end
  if (DEASSERT_CYCLES < 1) begin : g_bad_deassert
    $error("assert_deassert_filter: DEASSERT_CYCLES must be at least 1");
  end

  // Channels share nothing but clock, reset and enable.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    assert_deassert_filter_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .ASSERT_CYCLES  (ASSERT_CYCLES),
      .DEASSERT_CYCLES(DEASSERT_CYCLES),
      .RESET_VAL      (RESET_VAL)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .in   (in[i]),
      .out  (out[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule

// File: tb/tb_assert_deassert_filter.sv
// Self-checking bench for assert_deassert_filter with default parameters.
// Directed scenarios compare against hand-derived expectations; a randomized
// phase compares against a window-based reference model.
module tb_assert_deassert_filter;

  localparam int W    = 4;
  localparam int S    = 2;
  localparam int ATHR = 4;
  localparam int DTHR = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic [W-1:0] rise;
  logic [W-1:0] fall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assert_deassert_filter #(
    .WIDTH          (W),
    .SYNC_STAGES    (S),
    .ASSERT_CYCLES  (ATHR),
    .DEASSERT_CYCLES(DTHR),
    .RESET_VAL      (1'b0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .in   (din),
    .out  (dout),
    .rise (rise),
    .fall (fall)
  );

  // Reference model: a delay line for the synchroniser, then a history of
  // enabled synced samples. A channel flips once the last thr samples since
  // its window started all disagree with its current level.
  logic [W-1:0] pipe [S];
  logic [W-1:0] hist [$];
  int           win_start [W];
  logic [W-1:0] m_out  = '0;
  logic [W-1:0] m_rise = '0;
  logic [W-1:0] m_fall = '0;
  logic [W-1:0] m_s;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < S; k++) pipe[k] = '0;
      hist.delete();
      for (int c = 0; c < W; c++) win_start[c] = 0;
      m_out  = '0;
      m_rise = '0;
      m_fall = '0;
    end else begin
      m_s = pipe[S-1];
      for (int k = S - 1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = din;
      m_rise  = '0;
      m_fall  = '0;
      if (!en) begin
        hist.delete();
        for (int c = 0; c < W; c++) win_start[c] = 0;
      end else begin
        hist.push_back(m_s);
        for (int c = 0; c < W; c++) begin
          int  thr;
          bit  all_diff;
          thr = m_out[c] ? DTHR : ATHR;
          if (hist.size() - win_start[c] >= thr) begin
            all_diff = 1'b1;
            for (int j = hist.size() - thr; j < hist.size(); j++)
              if (hist[j][c] == m_out[c]) all_diff = 1'b0;
            if (all_diff) begin
              m_out[c]     = ~m_out[c];
              m_rise[c]    = m_out[c];
              m_fall[c]    = ~m_out[c];
              win_start[c] = hist.size();
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, expected the run to complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Holds reset for three edges; called and returns on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [W-1:0] exp_out, exp_rise;
    din = 4'hF; en = 1'b1; rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({dout, rise, fall} !== 12'h000) begin
        errors++;
        $display("[TB] FAIL reset_state: out=%h rise=%h fall=%h required out=0 rise=0 fall=0", dout, rise, fall);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      exp_out  = (e >= 6) ? 4'hF : 4'h0;
      exp_rise = (e == 6) ? 4'hF : 4'h0;
      checks++;
      if (dout !== exp_out || rise !== exp_rise || fall !== 4'h0) begin
        errors++;
        $display("[TB] FAIL reset_release edge %0d: out=%h rise=%h fall=%h required out=%h rise=%h fall=0", e, dout, rise, fall, exp_out, exp_rise);
      end
    end
  endtask

  task automatic test_assert();
    din = 4'h0;
    do_reset();
    din[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      checks++;
      if (dout !== {3'b000, 1'(e >= 6)} || rise !== {3'b000, 1'(e == 6)} || fall !== 4'h0) begin
        errors++;
        $display("[TB] FAIL assert edge %0d: out=%h rise=%h fall=%h required out=%0d rise=%0d fall=0", e, dout, rise, fall, e >= 6, e == 6);
      end
    end
  endtask

  task automatic test_short_pulse();
    din = 4'h0;
    do_reset();
    din[1] = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      @(negedge clk);
      checks++;
      if (dout !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
        errors++;
        $display("[TB] FAIL short_pulse edge %0d: out=%h rise=%h fall=%h required all 0", e, dout, rise, fall);
      end
      if (e == 3) din[1] = 1'b0;
      if (e >= 4 && e <= 10) begin
        #2 din[2] = 1'b1;
        #1 din[2] = 1'b0;
      end
    end
  endtask

  task automatic test_deassert();
    din = 4'h0;
    do_reset();
    din[0] = 1'b1;
    repeat (8) @(negedge clk);
    din[0] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      checks++;
      if (dout !== 4'h1 || rise !== 4'h0 || fall !== 4'h0) begin
        errors++;
        $display("[TB] FAIL deassert_reject edge %0d: out=%h rise=%h fall=%h required out=1 rise=0 fall=0", e, dout, rise, fall);
      end
      if (e == 7) din[0] = 1'b1;
    end
    din[0] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      checks++;
      if (dout !== {3'b000, 1'(e < 10)} || fall !== {3'b000, 1'(e == 10)} || rise !== 4'h0) begin
        errors++;
        $display("[TB] FAIL deassert edge %0d: out=%h rise=%h fall=%h required out=%0d fall=%0d rise=0", e, dout, rise, fall, e < 10, e == 10);
      end
    end
  endtask

  task automatic test_enable();
    din = 4'h0;
    do_reset();
    din[3] = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      checks++;
      if (dout !== {1'(e >= 14), 3'b000} || rise !== {1'(e == 14), 3'b000} || fall !== 4'h0) begin
        errors++;
        $display("[TB] FAIL enable edge %0d: out=%h rise=%h fall=%h required out[3]=%0d rise[3]=%0d others 0", e, dout, rise, fall, e >= 14, e == 14);
      end
      if (e == 5)  en = 1'b0;
      if (e == 10) en = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_out, exp_str;
    din = 4'h0;
    do_reset();
    din[1] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    din = 4'h0;
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      checks++;
      if (dout !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
        errors++;
        $display("[TB] FAIL aborted_count edge %0d: out=%h rise=%h fall=%h required all 0", e, dout, rise, fall);
      end
      if (e == 2) rst_n = 1'b1;
    end
    din = 4'hF;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      exp_out = (e >= 6) ? 4'hF : 4'h0;
      exp_str = (e == 6) ? 4'hF : 4'h0;
      checks++;
      if (dout !== exp_out || rise !== exp_str || fall !== 4'h0) begin
        errors++;
        $display("[TB] FAIL simultaneous_rise edge %0d: out=%h rise=%h fall=%h required out=%h rise=%h", e, dout, rise, fall, exp_out, exp_str);
      end
    end
    din = 4'h0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      exp_out = (e < 10) ? 4'hF : 4'h0;
      exp_str = (e == 10) ? 4'hF : 4'h0;
      checks++;
      if (dout !== exp_out || fall !== exp_str || rise !== 4'h0) begin
        errors++;
        $display("[TB] FAIL simultaneous_fall edge %0d: out=%h rise=%h fall=%h required out=%h fall=%h", e, dout, rise, fall, exp_out, exp_str);
      end
    end
  endtask

  task automatic test_random();
    din = 4'h0;
    en  = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      checks++;
      if (dout !== m_out || rise !== m_rise || fall !== m_fall) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: out=%h rise=%h fall=%h required out=%h rise=%h fall=%h", cyc, dout, rise, fall, m_out, m_rise, m_fall);
      end
      checks++;
      if ((rise & fall) !== 4'h0 || (rise & ~dout) !== 4'h0) begin
        errors++;
        $display("[TB] FAIL strobe_invariant cycle %0d: out=%h rise=%h fall=%h", cyc, dout, rise, fall);
      end
      for (int c = 0; c < W; c++)
        if ($urandom_range((cyc < 300) ? 5 : 11) == 0) din[c] = ~din[c];
      en    = ($urandom_range(19) != 0);
      rst_n = ($urandom_range(99) != 0);
    end
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  initial begin
    test_reset();
    test_assert();
    test_short_pulse();
    test_deassert();
    test_enable();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
